// File: rtl/eq_filter_sequencer_if.sv
// Control bundle between the equaliser sequencer and its host/datapath.
// The slave side is the sequencer; the master side supplies the sample
// strobe, enable and overrun clear, and consumes the MAC/history controls.
interface eq_filter_sequencer_if #(
    parameter int BAND_W = 2,
    parameter int TAP_W  = 3
);
    logic              en;
    logic              sample_tick;
    logic              ovr_clr;
    logic              busy;
    logic [BAND_W-1:0] band_o;
    logic [TAP_W-1:0]  tap_o;
    logic              mac_clr;
    logic              mac_en;
    logic              shift_en;
    logic              y_valid;
    logic              done;
    logic              ovr;

    modport master (
        output en, sample_tick, ovr_clr,
        input  busy, band_o, tap_o, mac_clr, mac_en, shift_en, y_valid, done, ovr
    );

    modport slave (
        input  en, sample_tick, ovr_clr,
        output busy, band_o, tap_o, mac_clr, mac_en, shift_en, y_valid, done, ovr
    );
endinterface

// File: rtl/eq_filter_sequencer.sv
// Equaliser MAC sequencer: on each sample strobe, walks every band through
// its taps on one shared multiply-accumulate unit, then issues a write-back
// cycle per band (MAC result valid, history load) and a final done pulse.
// All outputs are decoded from registered state only.
module eq_filter_sequencer #(
    parameter int N_BANDS = 3,
    parameter int N_TAPS  = 5,
    parameter int BAND_W  = 2,
    parameter int TAP_W   = 3
) (
    input logic                 clk,
    input logic                 rst,
    eq_filter_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(N_BANDS - 1);
    localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(N_TAPS - 1);

    state_t            state_q, state_d;
    logic [BAND_W-1:0] band_q,  band_d;
    logic [TAP_W-1:0]  tap_q,   tap_d;
    logic              ovr_q,   ovr_d;

    // State, band/tap counters and sticky overrun flag; reset aborts a pass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            band_q  <= '0;
            tap_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            band_q  <= band_d;
            tap_q   <= tap_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state: RUN steps the taps, WB advances the band, DONE returns home.
    always_comb begin
        state_d = state_q;
        band_d  = band_q;
        tap_d   = tap_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.sample_tick && bus.en) begin
                    state_d = S_RUN;
                    band_d  = '0;
                    tap_d   = '0;
                end
            end
            S_RUN: begin
                if (tap_q == TAP_LAST) begin
                    state_d = S_WB;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            S_WB: begin
                if (band_q == BAND_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                    band_d  = band_q + BAND_W'(1);
                    tap_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                band_d  = '0;
                tap_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                band_d  = '0;
                tap_d   = '0;
            end
        endcase
    end

    // Overrun: a tick while busy is dropped and flagged; a set beats a clear.
    always_comb begin
        ovr_d = ovr_q;
        if (bus.sample_tick && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
        end else if (bus.ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    // Moore output decode.
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.band_o   = band_q;
    assign bus.tap_o    = tap_q;
    assign bus.mac_en   = (state_q == S_RUN);
    assign bus.mac_clr  = (state_q == S_RUN) && (tap_q == '0);
    assign bus.shift_en = (state_q == S_WB);
    assign bus.y_valid  = (state_q == S_WB);
    assign bus.done     = (state_q == S_DONE);
    assign bus.ovr      = ovr_q;

endmodule

// File: doc/eq_filter_sequencer.md
Name: eq_filter_sequencer

Overview:
- Time-multiplexes one shared multiply-accumulate (MAC) unit across all equaliser bands.
- For each audio sample, it walks every band through its filter taps.
- Drives the coefficient/history mux selects, MAC clear/enable, and the per-band delay-line register load strobes (the largo+1-bit history registers).
- Sits between the sample-rate strobe from the codec interface and the filter datapath.

Parameters:
- N_BANDS, 3, number of equaliser bands sharing the MAC.
- N_TAPS, 5, MAC operations per band per sample (b0,b1,b2,a1,a2).
- BAND_W, 2, width of band index; 2**BAND_W >= N_BANDS.
- TAP_W, 3, width of tap index; 2**TAP_W >= N_TAPS.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- en  in  1  sequencer enable; gates only the start of a new sample pass.
- sample_tick  in  1  one-cycle pulse: new input sample latched and ready.
- ovr_clr  in  1  clears the overrun flag.
- busy  out  1  high while a sample pass is in progress (state != IDLE).
- band_o  out  BAND_W  band currently using the MAC (coefficient bank / history select).
- tap_o  out  TAP_W  tap index selecting coefficient and history word.
- mac_clr  out  1  load the accumulator with the product (first tap of a band).
- mac_en  out  1  accumulate the current product.
- shift_en  out  1  one-cycle load strobe for band_o's x/y history registers.
- y_valid  out  1  band_o's result is valid on the MAC output this cycle.
- done  out  1  one-cycle pulse: all bands processed for this sample.
- ovr  out  1  sticky: sample_tick arrived while busy.

Behaviour:
- All outputs are Moore decodes of registered state (state, band, tap, ovr). There is no combinational input-to-output path.

Reset (rst=0, asynchronous):
- state=IDLE, band=0, tap=0, ovr=0.
- All outputs 0.
- Reset mid-pass aborts immediately. No shift_en or done is issued for the aborted sample.

FSM states: IDLE, RUN, WB, DONE.
- IDLE: when sample_tick=1 and en=1 at a rising edge, go to RUN with band=0, tap=0. Otherwise stay.
- RUN:
  - mac_en=1; mac_clr=1 iff tap==0.
  - If tap < N_TAPS-1, tap increments.
  - If tap==N_TAPS-1, go to WB; tap holds.
- WB (MAC has 1-cycle pipeline latency; result valid here):
  - shift_en=1, y_valid=1, mac_en=0.
  - If band==N_BANDS-1, go to DONE.
  - Otherwise band increments, tap=0, go to RUN.
- DONE: done=1 for one cycle, then go to IDLE with band=0, tap=0.

Timing and outputs:
- Pass length is N_BANDS*(N_TAPS+1)+1 cycles after the start edge; 19 cycles with defaults.
- busy=1 in RUN, WB, DONE.
- band_o/tap_o hold their last value in WB. Both are 0 in IDLE.

Enable:
- en=0 in IDLE: sample_tick is ignored, with no ovr and no start.
- en deasserted mid-pass: the pass completes normally.

Overrun:
- sample_tick=1 while state != IDLE sets ovr and the tick is dropped (not queued).
- sample_tick in the DONE cycle counts as overrun.
- ovr_clr=1 clears ovr. If set and clear happen in the same cycle, set wins.
- ovr is not cleared by en.

Other rules:
- sample_tick held high for several cycles starts one pass, then flags ovr on every following cycle while busy.
- band and tap never exceed N_BANDS-1 and N_TAPS-1 respectively.

Test Plan:
- Basic pass:
  - Stimulus: reset low 3 cycles, release, en=1, one sample_tick.
  - Required: busy=1 for 19 cycles.
  - Required (tap sequence): tap_o per band is 0,1,2,3,4 then WB.
  - Required (MAC strobes): mac_clr high 3 times; mac_en high 15 cycles.
  - Required (done): shift_en/y_valid high 3 times with band_o=0,1,2; done pulses once at cycle 19; ovr=0.
- Enable gating: en=0, sample_tick pulse → busy stays 0, ovr stays 0.
- Overrun:
  - Stimulus: start a pass, then pulse sample_tick at cycle 7 and in the DONE cycle.
  - Required: ovr=1 from cycle 8 and remains set; only one done.
  - Then: ovr_clr pulse → ovr=0. ovr_clr coincident with a new busy-tick → ovr=1.
- Reset mid-pass: assert rst=0 asynchronously during band 1 tap 2 → all outputs 0 immediately; after release, no done or shift_en until the next tick.
- Back-to-back: sample_tick in the cycle after done (state IDLE) → new pass starts, ovr=0. Ticks every 20 cycles for 100 samples → 100 done pulses, 300 shift_en, ovr never set.
- Parameter sweep: N_BANDS=1, N_TAPS=3 → pass is 5 cycles, tap_o 0,1,2, one shift_en with band_o=0.
